// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one word request, waits LATENCY cycles, pulses a response.
// Optional DM_ERR_CHECK_EN flags misaligned or out-of-range addresses as errors instead of aliasing.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q;
    logic               write_q;
    logic               bad_q;
    logic [IDX_W-1:0]   idx_q;
    logic [31:0]        wdata_q;
    logic [31:0]        mem [DEPTH_WORDS];
    logic [31:0]        rdata_q;
    logic               err_q;

    logic               accept;
    logic               req_bad;
    logic               enter_resp;
    logic               eff_write;
    logic               eff_bad;
    logic [IDX_W-1:0]   eff_idx;
    logic [31:0]        eff_wdata;

`ifdef DM_ERR_CHECK_EN
    assign req_bad = (addr_i[1:0] != 2'b00) || (addr_i[31:IDX_W+2] != '0);
`else
    logic unused_addr_bits;
    assign req_bad          = 1'b0;
    assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};
`endif

    assign accept = req_valid_i && req_ready_o;

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (LATENCY == 0) ? S_RESP : S_WAIT;
            S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the state
    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        rsp_valid_o = (state_q == S_RESP);
    end

    // With LATENCY=0 the RESP-entry edge is the accept edge, so the live inputs are used there.
    assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
    assign eff_write  = (state_q == S_IDLE) ? req_write_i          : write_q;
    assign eff_bad    = (state_q == S_IDLE) ? req_bad              : bad_q;
    assign eff_idx    = (state_q == S_IDLE) ? addr_i[IDX_W+1:2]    : idx_q;
    assign eff_wdata  = (state_q == S_IDLE) ? wdata_i              : wdata_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            write_q <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            cnt_q   <= 4'(LATENCY);
            write_q <= req_write_i;
            bad_q   <= req_bad;
            idx_q   <= addr_i[IDX_W+1:2];
            wdata_q <= wdata_i;
        end else if (state_q == S_WAIT) begin
            cnt_q   <= cnt_q - 4'd1;
        end
    end

    // NOTE: the storage array is cleared by reset, so it is built from flops rather than a RAM macro.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (enter_resp && eff_write && !eff_bad) begin
            mem[eff_idx] <= eff_wdata;
        end
    end

    // Response data and error hold until the next response
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (enter_resp) begin
            rdata_q <= (eff_write || eff_bad) ? 32'h0 : mem[eff_idx];
            err_q   <= eff_bad;
        end
    end

    assign rdata_o = rdata_q;
    assign err_o   = err_q;
endmodule
